// File: rtl/mod_exp_pkg.sv
`default_nettype none
// ============================================================================
// mod_exp_pkg -- shared widths and FSM encodings for mod_exp_ctrl.   Rev 1.0
// ============================================================================
package mod_exp_pkg;

  localparam int WIDTH_DEF     = 192;
  localparam int EXP_WIDTH_DEF = 192;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TOM  = 3'd1,
    ST_ONE  = 3'd2,
    ST_SCAN = 3'd3,
    ST_SQR  = 3'd4,
    ST_MUL  = 3'd5,
    ST_FROM = 3'd6,
    ST_FIN  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CALL_IDLE  = 2'd0,
    CALL_SETUP = 2'd1,
    CALL_WAIT  = 2'd2,
    CALL_GAP   = 2'd3
  } call_state_e;

endpackage
`default_nettype wire

// File: rtl/mod_exp_ctrl_mm_call_if.sv
`default_nettype none
// ============================================================================
// mm_call_if -- one Montgomery-multiplier call: setup, hold, capture, gap. Rev 1.0
// ============================================================================
module mm_call_if
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ack_o,
  output logic [WIDTH-1:0] z_o,
  output logic [WIDTH-1:0] mm_x_o,
  output logic [WIDTH-1:0] mm_y_o,
  output logic             mm_start_o,
  input  logic [WIDTH-1:0] mm_z_i,
  input  logic             mm_done_i
);

  call_state_e      state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic             start_q;
  logic             ack_q;

  // GAP lasts at least one cycle, so a requester that drops req on ack is
  // never re-accepted for the call that just finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CALL_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        CALL_IDLE: begin
          if (req_i) begin
            x_q     <= a_i;
            y_q     <= b_i;
            state_q <= CALL_SETUP;
          end
        end
        CALL_SETUP: begin
          if (!mm_done_i) begin
            start_q <= 1'b1;
            state_q <= CALL_WAIT;
          end
        end
        CALL_WAIT: begin
          if (mm_done_i) begin
            z_q     <= mm_z_i;
            ack_q   <= 1'b1;
            start_q <= 1'b0;
            state_q <= CALL_GAP;
          end
        end
        CALL_GAP: begin
          if (!mm_done_i) state_q <= CALL_IDLE;
        end
        default: state_q <= CALL_IDLE;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign z_o        = z_q;
  assign mm_x_o     = x_q;
  assign mm_y_o     = y_q;
  assign mm_start_o = start_q;

endmodule
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// mod_exp_ctrl -- square-and-multiply base^exponent mod N over a Montgomery
// multiplier.                                                          Rev 1.0
// ============================================================================
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     r2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     mm_x,
  output logic [WIDTH-1:0]     mm_y,
  output logic                 mm_start,
  input  logic [WIDTH-1:0]     mm_z,
  input  logic                 mm_done
);

  localparam int               CW   = $clog2(EXP_WIDTH) + 1;
  localparam logic [WIDTH-1:0] UNIT = WIDTH'(1);

  state_e               state_q;
  logic [WIDTH-1:0]     base_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]     r2_q;
  logic [WIDTH-1:0]     bm_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [CW-1:0]        idx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 req_q;

  logic                 ack;
  logic [WIDTH-1:0]     call_z;
  logic                 exp_bit;
  logic                 last_bit;

  assign exp_bit  = exp_q[idx_q[CW-2:0]];
  assign last_bit = (idx_q == '0);

  mm_call_if #(.WIDTH(WIDTH)) u_call (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .ack_o      (ack),
    .z_o        (call_z),
    .mm_x_o     (mm_x),
    .mm_y_o     (mm_y),
    .mm_start_o (mm_start),
    .mm_z_i     (mm_z),
    .mm_done_i  (mm_done)
  );

  // Each call state raises req once with its operands, then waits for ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      r2_q     <= '0;
      bm_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exponent;
            r2_q    <= r2;
            idx_q   <= CW'(EXP_WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= ST_TOM;
          end
        end
        ST_TOM: begin
          if (ack) begin
            bm_q    <= call_z;
            req_q   <= 1'b0;
            state_q <= ST_ONE;
          end else if (!req_q) begin
            req_q <= 1'b1;
            a_q   <= base_q;
            b_q   <= r2_q;
          end
        end
        ST_ONE: begin
          if (ack) begin
            acc_q   <= call_z;
            req_q   <= 1'b0;
            state_q <= ST_SCAN;
          end else if (!req_q) begin
            req_q <= 1'b1;
            a_q   <= UNIT;
            b_q   <= r2_q;
          end
        end
        ST_SCAN: begin
          if (exp_q == '0) begin
            state_q <= ST_FROM;
          end else if (exp_bit) begin
            state_q <= ST_SQR;
          end else begin
            idx_q <= idx_q - CW'(1);
          end
        end
        ST_SQR: begin
          if (ack) begin
            acc_q <= call_z;
            req_q <= 1'b0;
            if (exp_bit) begin
              state_q <= ST_MUL;
            end else if (last_bit) begin
              state_q <= ST_FROM;
            end else begin
              idx_q <= idx_q - CW'(1);
            end
          end else if (!req_q) begin
            req_q <= 1'b1;
            a_q   <= acc_q;
            b_q   <= acc_q;
          end
        end
        ST_MUL: begin
          if (ack) begin
            acc_q <= call_z;
            req_q <= 1'b0;
            if (last_bit) begin
              state_q <= ST_FROM;
            end else begin
              idx_q   <= idx_q - CW'(1);
              state_q <= ST_SQR;
            end
          end else if (!req_q) begin
            req_q <= 1'b1;
            a_q   <= acc_q;
            b_q   <= bm_q;
          end
        end
        ST_FROM: begin
          if (ack) begin
            acc_q   <= call_z;
            req_q   <= 1'b0;
            state_q <= ST_FIN;
          end else if (!req_q) begin
            req_q <= 1'b1;
            a_q   <= acc_q;
            b_q   <= UNIT;
          end
        end
        ST_FIN: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mod_exp_ctrl -- mod_exp_ctrl against a pow-mod reference and a behavioural
// Montgomery multiplier (N=239, R=256, r2=50, latency 10).             Rev 1.0
// ============================================================================
module tb_mod_exp_ctrl;

  localparam int N    = 239;
  localparam int RINV = 225;  // 256^-1 mod 239
  localparam int LAT  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base = '0;
  logic [7:0] exponent = '0;
  logic [7:0] r2 = 8'd50;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] mm_x;
  logic [7:0] mm_y;
  logic       mm_start;
  logic [7:0] mm_z;
  logic       mm_done;

  int vectors = 0;
  int miscompares = 0;
  int rises = 0;
  int dones = 0;
  int extra_hold = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .r2       (r2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mm_x     (mm_x),
    .mm_y     (mm_y),
    .mm_start (mm_start),
    .mm_z     (mm_z),
    .mm_done  (mm_done)
  );

  function automatic int mont(input int x, input int y);
    return (x * y * RINV) % N;
  endfunction

  function automatic int powmod(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % N;
    return r;
  endfunction

  function automatic int exp_calls(input logic [7:0] e);
    int l = 0;
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) begin
        l = i + 1;
        p++;
      end
    end
    return 3 + l + p;
  endfunction

  // Behavioural multiplier: done after LAT cycles of start, held until start
  // drops plus extra_hold cycles.
  int lat_cnt;
  int hold_left;
  always @(posedge clk) begin
    if (reset) begin
      mm_done   <= 1'b0;
      mm_z      <= '0;
      lat_cnt   <= 0;
      hold_left <= 0;
    end else if (mm_done) begin
      if (!mm_start) begin
        if (hold_left > 0) hold_left <= hold_left - 1;
        else mm_done <= 1'b0;
      end
    end else if (mm_start) begin
      if (lat_cnt == LAT - 1) begin
        mm_done   <= 1'b1;
        mm_z      <= 8'(mont(int'(mm_x), int'(mm_y)));
        lat_cnt   <= 0;
        hold_left <= extra_hold;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // Protocol monitor: counts calls and done pulses, checks operand stability
  // and that start never rises while the multiplier still reports done.
  logic       ms_prev = 1'b0;
  logic       md_prev = 1'b0;
  logic [7:0] x_prev = '0;
  logic [7:0] y_prev = '0;
  always @(negedge clk) begin
    if (mm_start && !ms_prev) begin
      rises++;
      assert (!md_prev) else begin
        miscompares++;
        $error("FAIL start_while_done observed=1 expected=0");
      end
    end
    if (mm_start && ms_prev) begin
      assert (mm_x === x_prev && mm_y === y_prev) else begin
        miscompares++;
        $error("FAIL operand_hold observed=%0d/%0d expected=%0d/%0d", mm_x, mm_y, x_prev, y_prev);
      end
    end
    if (done) dones++;
    ms_prev = mm_start;
    md_prev = mm_done;
    x_prev  = mm_x;
    y_prev  = mm_y;
  end

  task automatic chk(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic kick(input logic [7:0] b, input logic [7:0] e);
    @(posedge clk); #1;
    rises    = 0;
    dones    = 0;
    base     = b;
    exponent = e;
    r2       = 8'd50;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    base     = 8'($urandom);
    exponent = 8'($urandom);
  endtask

  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input bit pulses, input string tag);
    bit seen = 1'b0;
    int res  = powmod(int'(b), int'(e));
    int kept;
    kick(b, e);
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "_busy"}, int'(busy), 1);
      if (done) seen = 1'b1;
      else if (pulses) start = (c == 5 || c == 20 || c == 40);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_result"}, int'(result), res);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_calls"}, rises, exp_calls(e));
    kept = int'(result);
    repeat (3) @(negedge clk);
    chk({tag, "_one_done"}, dones, 1);
    chk({tag, "_result_held"}, int'(result), kept);
  endtask

  initial begin
    int rb;
    int re;
    bit hit;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mm_start", int'(mm_start), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mm_x", int'(mm_x), 0);
    chk("rst_mm_y", int'(mm_y), 0);

    run_op(8'd3, 8'd5, 1'b0, "t1_3pow5");
    chk("t1_value4", int'(result), 4);
    run_op(8'd200, 8'd0, 1'b0, "t2_exp0");
    chk("t2_exp0_is1", int'(result), 1);
    run_op(8'd200, 8'd1, 1'b0, "t2_exp1");
    run_op(8'd0, 8'd7, 1'b0, "t3_base0");
    run_op(8'd17, 8'd255, 1'b0, "t3_17pow255");
    run_op(8'd3, 8'd5, 1'b1, "t4_ignored_starts");

    // Reset during the first squaring call.
    kick(8'd3, 8'd5);
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if (rises >= 3) hit = 1'b1;
    end
    chk("t5_reached_sqr", int'(hit), 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_mm_start", int'(mm_start), 0);
    chk("t5_done", int'(done), 0);
    repeat (40) @(negedge clk);
    chk("t5_no_done", dones, 0);
    chk("t5_still_idle", int'(mm_start), 0);
    run_op(8'd3, 8'd5, 1'b0, "t5_after_reset");

    extra_hold = 3;
    run_op(8'd3, 8'd5, 1'b0, "t6_long_done");
    run_op(8'd17, 8'd11, 1'b0, "t6_long_done_b");
    extra_hold = 0;

    for (int k = 0; k < 4; k++) begin
      rb = int'($urandom_range(0, N - 1));
      re = int'($urandom_range(0, 255));
      run_op(8'(rb), 8'(re), 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
